// File: rtl/hilo_div_unit_if.sv
// hilo_div_unit_if: CPU/divider-facing bus of the HI/LO divide sequencer
// master: CPU side drives start/is_signed/op_a/op_b/hi_we/lo_we/wdata and the divider's quotient/remainder
// slave : sequencer drives div_dividend/div_divisor, busy/done/div_zero and hi/lo
interface hilo_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (
    output start, is_signed, op_a, op_b, hi_we, lo_we, wdata, div_quotient, div_remainder,
    input  div_dividend, div_divisor, busy, done, div_zero, hi, lo
  );
  modport slave (
    input  start, is_signed, op_a, op_b, hi_we, lo_we, wdata, div_quotient, div_remainder,
    output div_dividend, div_divisor, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: sequences DIV/DIVU through a multicycle combinational divider and owns HI/LO
// clk/reset: clock and synchronous active-high reset
// bus (slave): operands, MTHI/MTLO writes, divider operand/result pair, busy/done/div_zero, hi/lo
module hilo_div_unit #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  hilo_div_unit_if.slave   bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  // the most negative value negates to itself, which is its correct unsigned magnitude
  assign w_abs_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign w_abs_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  // divide by zero ignores the divider: LO all ones, HI keeps the raw dividend
  assign w_q = r_zero ? '1  : (r_neg_q ? -bus.div_quotient  : bus.div_quotient);
  assign w_r = r_zero ? r_a : (r_neg_r ? -bus.div_remainder : bus.div_remainder);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_dvd   <= w_abs_a;
          r_dvs   <= w_abs_b;
          r_neg_q <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          r_neg_r <= bus.is_signed & bus.op_a[WIDTH-1];
          r_zero  <= (bus.op_b == '0);
          r_a     <= bus.op_a;
          r_cnt   <= 4'(DIV_CYCLES - 1);
          r_state <= S_WAIT;
        end else begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_lo    <= w_q;
        r_hi    <= w_r;
        r_done  <= 1'b1;
        r_dz    <= r_zero;
        r_state <= S_IDLE;
      end
    end
  end
  assign bus.div_dividend = r_dvd;
  assign bus.div_divisor  = r_dvs;
  assign bus.busy         = (r_state == S_WAIT);
  assign bus.done         = r_done;
  assign bus.div_zero     = r_dz;
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: randomized and directed self-checking bench for hilo_div_unit
module tb_hilo_div_unit;
  localparam int W  = 32;
  localparam int DC = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  hilo_div_unit_if #(.WIDTH(W)) bus();
  hilo_div_unit #(.WIDTH(W), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.div_quotient  = (bus.div_divisor == '0) ? '0 : bus.div_dividend / bus.div_divisor;
  assign bus.div_remainder = (bus.div_divisor == '0) ? '0 : bus.div_dividend % bus.div_divisor;
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] h, output logic [W-1:0] l, output bit z);
    z = (b == '0);
    if (z) begin
      h = a;
      l = '1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      h = '0;
      l = 32'h8000_0000;
    end else if (s) begin
      l = $signed(a) / $signed(b);
      h = $signed(a) % $signed(b);
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    bus.op_a = a;
    bus.op_b = b;
    bus.is_signed = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.hi, bus.lo, bus.div_dividend, bus.div_divisor} !== '0) begin
      fails++;
      $display("FAIL reset_regs hi=%h lo=%h dvd=%h dvs=%h required all 0", bus.hi, bus.lo, bus.div_dividend, bus.div_divisor);
    end
    tests++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags busy/done/dz=%b required 000", {bus.busy, bus.done, bus.div_zero});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic check_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit chk_mag);
    logic [W-1:0] eh, el;
    bit ez, ok;
    int n;
    model(a, b, s, eh, el, ez);
    issue(a, b, s);
    if (chk_mag) begin
      tests++;
      if (bus.div_dividend !== (s && a[W-1] ? -a : a) || bus.div_divisor !== (s && b[W-1] ? -b : b)) begin
        fails++;
        $display("FAIL %s_mag dvd=%h dvs=%h", name, bus.div_dividend, bus.div_divisor);
      end
    end
    wait_done(n, ok);
    tests++;
    if (!ok || n != DC) begin
      fails++;
      $display("FAIL %s_latency done=%b busy_cycles=%0d required 1/%0d", name, ok, n, DC);
    end
    tests++;
    if (bus.lo !== el || bus.hi !== eh || bus.div_zero !== ez) begin
      fails++;
      $display("FAIL %s a=%h b=%h s=%b lo=%h hi=%h dz=%b required lo=%h hi=%h dz=%b", name, a, b, s, bus.lo, bus.hi, bus.div_zero, el, eh, ez);
    end
    @(negedge clk);
  endtask
  task automatic test_directed;
    check_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b1);
    check_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    check_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_div("divu_big", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    check_div("div_zero", 32'h1234, 32'h0, 1'b0, 1'b0);
    check_div("div_zero_s", 32'h8000_0007, 32'h0, 1'b1, 1'b0);
    check_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
  endtask
  task automatic test_random;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      check_div("rand", a, b, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask
  task automatic test_busy_interference;
    int n;
    bit ok;
    issue(32'd100, 32'd7, 1'b0);
    bus.op_a = 32'd5;
    bus.op_b = 32'd1;
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hAA;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_done(n, ok);
    tests++;
    if (!ok || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      fails++;
      $display("FAIL busy_ignore done=%b lo=%h hi=%h required lo=e hi=2", ok, bus.lo, bus.hi);
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.lo !== 32'd14) begin
      fails++;
      $display("FAIL busy_no_queue busy=%b lo=%h required 0/e", bus.busy, bus.lo);
    end
  endtask
  task automatic test_mt;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h55;
    @(negedge clk);
    bus.lo_we = 1'b0;
    tests++;
    if (bus.lo !== 32'h55 || bus.hi !== 32'd2) begin
      fails++;
      $display("FAIL mtlo lo=%h hi=%h required 55/2", bus.lo, bus.hi);
    end
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    tests++;
    if (bus.lo !== 32'h1234_5678 || bus.hi !== 32'h1234_5678) begin
      fails++;
      $display("FAIL mthi_mtlo lo=%h hi=%h required 12345678", bus.lo, bus.hi);
    end
  endtask
  task automatic test_start_priority;
    int n;
    bit ok;
    bus.lo_we = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAA;
    issue(32'd100, 32'd7, 1'b0);
    bus.lo_we = 1'b0;
    bus.hi_we = 1'b0;
    tests++;
    if (bus.lo === 32'hAA || bus.hi === 32'hAA) begin
      fails++;
      $display("FAIL start_prio_write lo=%h hi=%h required not aa", bus.lo, bus.hi);
    end
    wait_done(n, ok);
    tests++;
    if (!ok || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      fails++;
      $display("FAIL start_prio_result done=%b lo=%h hi=%h required e/2", ok, bus.lo, bus.hi);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int seen = 0;
    issue(32'd100, 32'd7, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h done=%b required 0", bus.busy, bus.hi, bus.lo, bus.done);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    tests++;
    if (seen != 0 || bus.lo !== '0) begin
      fails++;
      $display("FAIL reset_mid_no_done activity=%0d lo=%h required 0/0", seen, bus.lo);
    end
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] eh, el;
    bit ez, ok;
    int n;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(n, ok);
    tests++;
    if (!ok || bus.lo !== 32'd14) begin
      fails++;
      $display("FAIL b2b_first done=%b lo=%h required 1/e", ok, bus.lo);
    end
    model(32'hFFFF_FF00, 32'd9, 1'b1, eh, el, ez);
    issue(32'hFFFF_FF00, 32'd9, 1'b1);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept busy=%b required 1", bus.busy);
    end
    wait_done(n, ok);
    tests++;
    if (!ok || n != DC || bus.lo !== el || bus.hi !== eh || bus.div_zero !== ez) begin
      fails++;
      $display("FAIL b2b_second done=%b n=%0d lo=%h hi=%h required lo=%h hi=%h", ok, n, bus.lo, bus.hi, el, eh);
    end
    @(negedge clk);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_busy_interference;
    test_mt;
    test_start_priority;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
